// File: rtl/mul_pkg.sv
// Shared types and widths for the multiply-accumulate path that sits behind
// the 32x32 shift-add multiplier.
package mul_pkg;

  // Width of the product coming out of the multiplier.
  localparam int PROD_W = 64;

  // Width of the accumulated group sum carried in every buffer entry.
  localparam int ACC_W = 64;

  // One finished group: its sum, how many products went into it, and
  // whether any addition within the group overflowed.
  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [7:0]       terms;
    logic             ovf;
  } acc_entry_t;

endpackage

// File: rtl/mul_product_accumulator_if.sv
// Product-in / group-sum-out handshake bundle for mul_product_accumulator.
// The master side is whoever feeds products and drains sums; the slave side
// is the accumulator itself.
interface mul_product_accumulator_if #(
  parameter int PROD_W = mul_pkg::PROD_W,
  parameter int ACC_W  = mul_pkg::ACC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [7:0]        out_terms;
  logic              out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_terms, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_terms, out_ovf
  );

endinterface

// File: rtl/mul_acc_out_fifo.sv
// Two-entry, strictly ordered buffer of finished group results.  The head
// entry is always held in slot0 so the outputs come straight from a register;
// after the last entry is popped slot0 keeps its old contents.
module mul_acc_out_fifo
  import mul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  acc_entry_t push_data,
  input  logic       pop,
  output acc_entry_t head_data,
  output logic       full,
  output logic       empty
);

  acc_entry_t slot0;
  acc_entry_t slot1;
  logic [1:0] count;

  // Slot and occupancy update; a simultaneous push and pop keeps the
  // occupancy and moves the queue forward by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= push_data;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            slot1 <= push_data;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            count <= 2'd0;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
            count <= 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head_data = slot0;
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/mul_product_accumulator.sv
// Sums multiplier products into groups and hands each finished group
// (sum, term count, overflow flag) to the next stage through a 2-entry buffer.
// A group closes on in_last or when it reaches MAX_TERMS products.
module mul_product_accumulator
  import mul_pkg::*;
#(
  parameter int PROD_W    = mul_pkg::PROD_W,
  parameter int ACC_W     = mul_pkg::ACC_W,
  parameter int MAX_TERMS = 16,
  parameter int SATURATE  = 1
) (
  input logic                     clk,
  input logic                     rst,
  mul_product_accumulator_if.slave bus
);

  localparam logic [7:0] MAX_TERMS_W = 8'(MAX_TERMS);

  logic [ACC_W-1:0] acc;
  logic [7:0]       terms;
  logic             group_ovf;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic [7:0]       terms_next;
  logic             ovf_next;
  logic             accept;
  logic             close;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  acc_entry_t       push_data;
  acc_entry_t       head_data;

  // Next group state for the beat on the input; the extra top bit of the
  // add is the carry that marks overflow.  With saturation on, an overflowed
  // group sits at all-ones, and adding to all-ones keeps it there.
  always_comb begin
    sum_wide   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
    ovf_next   = group_ovf | sum_wide[ACC_W];
    sum_next   = sum_wide[ACC_W-1:0];
    if ((SATURATE != 0) && ovf_next) begin
      sum_next = '1;
    end
    terms_next = terms + 8'd1;
    close      = bus.in_last || (terms_next == MAX_TERMS_W);
    push_data       = '0;
    push_data.sum   = sum_next;
    push_data.terms = terms_next;
    push_data.ovf   = ovf_next;
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && close;
  assign pop    = bus.out_valid && bus.out_ready;

  // Running group state: advance on every accepted beat and start over
  // from zero on the beat that closes the group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      terms     <= 8'd0;
      group_ovf <= 1'b0;
    end else if (accept) begin
      if (close) begin
        acc       <= '0;
        terms     <= 8'd0;
        group_ovf <= 1'b0;
      end else begin
        acc       <= sum_next;
        terms     <= terms_next;
        group_ovf <= ovf_next;
      end
    end
  end

  mul_acc_out_fifo u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // in_ready only looks at buffer occupancy, which is itself a register, so
  // nothing from out_ready reaches it within the same cycle.
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_sum   = head_data.sum;
  assign bus.out_terms = head_data.terms;
  assign bus.out_ovf   = head_data.ovf;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Bench for mul_product_accumulator.  Three instances with different
// MAX_TERMS/SATURATE settings; a true-sum reference model tracks each one.
module tb_mul_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0]       in_valid;
  logic [2:0]       in_last;
  logic [2:0]       out_ready;
  logic [2:0][63:0] in_product;
  logic [2:0]       in_ready;
  logic [2:0]       out_valid;
  logic [2:0]       out_ovf;
  logic [2:0][63:0] out_sum;
  logic [2:0][7:0]  out_terms;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit collect_en = 1'b0;
  logic [63:0] pop_q[$];
  int waited;

  always #5 clk = ~clk;

  // Instance 0: 16 terms, saturating.  1: 4 terms, wrapping.  2: 1 term, saturating.
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int MT  = (g == 0) ? 16 : ((g == 1) ? 4 : 1);
    localparam int SAT = (g == 1) ? 0 : 1;
    mul_product_accumulator_if #(.PROD_W(64), .ACC_W(64)) bus ();
    assign bus.in_valid   = in_valid[g];
    assign bus.in_product = in_product[g];
    assign bus.in_last    = in_last[g];
    assign bus.out_ready  = out_ready[g];
    assign in_ready[g]    = bus.in_ready;
    assign out_valid[g]   = bus.out_valid;
    assign out_sum[g]     = bus.out_sum;
    assign out_terms[g]   = bus.out_terms;
    assign out_ovf[g]     = bus.out_ovf;
    mul_product_accumulator #(
      .PROD_W(64), .ACC_W(64), .MAX_TERMS(MT), .SATURATE(SAT)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  function automatic int max_t(input int d);
    return (d == 0) ? 16 : ((d == 1) ? 4 : 1);
  endfunction

  function automatic bit sat_on(input int d);
    return (d != 1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the group's exact sum in 128 bits; overflow means the
  // exact sum reached 2^64, the reported sum is then all-ones or the low bits.
  logic [127:0] m_true [3];
  int           m_terms[3];
  int           m_cnt  [3];
  logic [63:0]  m_sum  [3][2];
  logic [7:0]   m_tq   [3][2];
  logic         m_oq   [3][2];

  task automatic modelStep(input int d);
    bit do_pop, do_acc, do_push;
    logic [63:0] s;
    logic ovf;
    int t;
    do_pop  = (m_cnt[d] > 0) && out_ready[d];
    do_acc  = in_valid[d] && (m_cnt[d] < 2);
    do_push = 1'b0;
    s = '0; ovf = 1'b0; t = 0;
    if (do_acc) begin
      m_true[d] = m_true[d] + {64'd0, in_product[d]};
      m_terms[d]++;
      if (in_last[d] || m_terms[d] == max_t(d)) begin
        ovf = (m_true[d][127:64] != 64'd0);
        s = (ovf && sat_on(d)) ? 64'hFFFF_FFFF_FFFF_FFFF : m_true[d][63:0];
        t = m_terms[d];
        do_push = 1'b1;
        m_true[d] = '0;
        m_terms[d] = 0;
      end
    end
    if (do_pop) begin
      m_sum[d][0] = m_sum[d][1];
      m_tq[d][0]  = m_tq[d][1];
      m_oq[d][0]  = m_oq[d][1];
      m_cnt[d]--;
    end
    if (do_push) begin
      m_sum[d][m_cnt[d]] = s;
      m_tq[d][m_cnt[d]]  = 8'(t);
      m_oq[d][m_cnt[d]]  = ovf;
      m_cnt[d]++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_true[d] = '0;
        m_terms[d] = 0;
        m_cnt[d] = 0;
      end else begin
        modelStep(d);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("dut%0d in_ready", d), 64'(in_ready[d]), 64'(m_cnt[d] < 2));
        checkOutput($sformatf("dut%0d out_valid", d), 64'(out_valid[d]), 64'(m_cnt[d] > 0));
        if (m_cnt[d] > 0) begin
          checkOutput($sformatf("dut%0d out_sum", d), out_sum[d], m_sum[d][0]);
          checkOutput($sformatf("dut%0d out_terms", d), 64'(out_terms[d]), 64'(m_tq[d][0]));
          checkOutput($sformatf("dut%0d out_ovf", d), 64'(out_ovf[d]), 64'(m_oq[d][0]));
        end
      end
    end
  end

  // Records each head value of instance 0 that is about to be popped.
  always @(negedge clk) begin
    if (collect_en && !rst && out_valid[0] && out_ready[0]) begin
      pop_q.push_back(out_sum[0]);
    end
  end

  typedef struct {
    int          dut;
    logic [63:0] product;
    bit          last;
    bit          exp_out;
    logic [63:0] exp_sum;
    logic [7:0]  exp_terms;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic [63:0] p, input bit l, input bit eo,
                              input logic [63:0] s, input logic [7:0] t, input bit o);
    vec_t v;
    v.dut = d; v.product = p; v.last = l; v.exp_out = eo;
    v.exp_sum = s; v.exp_terms = t; v.exp_ovf = o;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    in_valid[v.dut]   = 1'b1;
    in_product[v.dut] = v.product;
    in_last[v.dut]    = v.last;
  endtask

  // Hold a beat on instance d until it is taken; called and returns at a negedge.
  task automatic sendBeat(input int d, input logic [63:0] p, input bit last, output int w);
    bit taken;
    bit done;
    done = 1'b0;
    w = 0;
    in_valid[d] = 1'b1;
    in_product[d] = p;
    in_last[d] = last;
    for (int i = 0; i < 50; i++) begin
      taken = in_ready[d];
      @(negedge clk);
      if (taken) begin
        done = 1'b1;
        break;
      end
      w++;
    end
    checkOutput($sformatf("dut%0d beat accepted in time", d), 64'(done), 64'd1);
  endtask

  task automatic idle(input int d);
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  function automatic logic [63:0] rand_prod();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, 1000));
      1:       return {$urandom(), $urandom()};
      2:       return {32'hFFFF_FFFF, $urandom()};
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] exp_q[$];
    in_valid = '0;
    in_last = '0;
    in_product = '0;
    out_ready = 3'b111;

    #2;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("dut%0d reset out_valid", d), 64'(out_valid[d]), 64'd0);
      checkOutput($sformatf("dut%0d reset out_sum", d), out_sum[d], 64'd0);
      checkOutput($sformatf("dut%0d reset out_terms", d), 64'(out_terms[d]), 64'd0);
      checkOutput($sformatf("dut%0d reset out_ovf", d), 64'(out_ovf[d]), 64'd0);
      checkOutput($sformatf("dut%0d reset in_ready", d), 64'(in_ready[d]), 64'd1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    vecs.push_back(mk(0, 64'd3, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0));
    vecs.push_back(mk(0, 64'd5, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0));
    vecs.push_back(mk(0, 64'd7, 1'b1, 1'b1, 64'd15, 8'd3, 1'b0));
    vecs.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0));
    vecs.push_back(mk(0, 64'h20, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd2, 1'b1));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0));
    vecs.push_back(mk(1, 64'h20, 1'b1, 1'b1, 64'h10, 8'd2, 1'b1));
    for (int k = 1; k <= 8; k++) begin
      vecs.push_back(mk(1, 64'd1, 1'b0, (k % 4) == 0, 64'd4, 8'd4, 1'b0));
    end
    vecs.push_back(mk(2, 64'd5, 1'b0, 1'b1, 64'd5, 8'd1, 1'b0));
    vecs.push_back(mk(2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 1'b0));
    vecs.push_back(mk(2, 64'd0, 1'b1, 1'b1, 64'd0, 8'd1, 1'b0));
    vecs.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0));
    vecs.push_back(mk(0, 64'd1, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0));
    vecs.push_back(mk(0, 64'd2, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd3, 1'b1));
    for (int k = 1; k <= 16; k++) begin
      vecs.push_back(mk(0, 64'd2, 1'b0, k == 16, 64'd32, 8'd16, 1'b0));
    end

    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        vec_t p;
        p = vecs[i-1];
        checkOutput($sformatf("vec%0d out_valid", i-1), 64'(out_valid[p.dut]), 64'(p.exp_out));
        if (p.exp_out) begin
          checkOutput($sformatf("vec%0d out_sum", i-1), out_sum[p.dut], p.exp_sum);
          checkOutput($sformatf("vec%0d out_terms", i-1), 64'(out_terms[p.dut]), 64'(p.exp_terms));
          checkOutput($sformatf("vec%0d out_ovf", i-1), 64'(out_ovf[p.dut]), 64'(p.exp_ovf));
        end
      end
      in_valid = '0;
      in_last = '0;
      if (i < vecs.size()) applyStimulus(vecs[i]);
    end

    // Backpressure: three single-beat groups while the consumer is stalled.
    @(posedge clk); #1 out_ready[0] = 1'b0;
    pop_q.delete();
    collect_en = 1'b1;
    @(negedge clk);
    sendBeat(0, 64'd10, 1'b1, waited);
    sendBeat(0, 64'd20, 1'b1, waited);
    checkOutput("in_ready low when full", 64'(in_ready[0]), 64'd0);
    checkOutput("head held while stalled", out_sum[0], 64'd10);
    fork
      sendBeat(0, 64'd30, 1'b1, waited);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    idle(0);
    checkOutput("third beat stall cycles", 64'(waited), 64'd4);
    repeat (4) @(negedge clk);
    exp_q = '{64'd10, 64'd20, 64'd30};
    checkOutput("stall pop count", 64'(pop_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < pop_q.size(); k++)
      checkOutput($sformatf("stall pop%0d", k), pop_q[k], exp_q[k]);

    // Full buffer drained while a back-to-back stream keeps arriving.
    @(posedge clk); #1 out_ready[0] = 1'b0;
    pop_q.delete();
    @(negedge clk);
    sendBeat(0, 64'd100, 1'b1, waited);
    sendBeat(0, 64'd200, 1'b1, waited);
    idle(0);
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 5; k++) sendBeat(0, 64'(k), 1'b1, waited);
    idle(0);
    repeat (8) @(negedge clk);
    exp_q = '{64'd100, 64'd200, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
    checkOutput("stream pop count", 64'(pop_q.size()), 64'd7);
    for (int k = 0; k < 7 && k < pop_q.size(); k++)
      checkOutput($sformatf("stream pop%0d", k), pop_q[k], exp_q[k]);
    collect_en = 1'b0;

    // Asynchronous reset with a buffered result and a partial group.
    @(posedge clk); #1 out_ready[0] = 1'b0;
    @(negedge clk);
    sendBeat(0, 64'd77, 1'b1, waited);
    sendBeat(0, 64'd9, 1'b0, waited);
    sendBeat(0, 64'd9, 1'b0, waited);
    idle(0);
    checkOutput("pre-reset head", out_sum[0], 64'd77);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset out_valid", 64'(out_valid[0]), 64'd0);
    checkOutput("async reset out_sum", out_sum[0], 64'd0);
    checkOutput("async reset out_terms", 64'(out_terms[0]), 64'd0);
    checkOutput("async reset out_ovf", 64'(out_ovf[0]), 64'd0);
    checkOutput("async reset in_ready", 64'(in_ready[0]), 64'd1);
    #3 rst = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    sendBeat(0, 64'd4, 1'b1, waited);
    idle(0);
    checkOutput("post-reset out_valid", 64'(out_valid[0]), 64'd1);
    checkOutput("post-reset out_sum", out_sum[0], 64'd4);
    checkOutput("post-reset out_terms", 64'(out_terms[0]), 64'd1);

    // Random traffic on all instances against the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        in_valid[d]   = 1'($urandom_range(0, 1));
        in_last[d]    = ($urandom_range(0, 3) == 0);
        in_product[d] = rand_prod();
        out_ready[d]  = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk);
    in_valid = '0;
    in_last = '0;
    out_ready = 3'b111;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
